// File: rtl/alu_datapath_sync.sv
`default_nettype none
// ============================================================================
// Module      : alu_datapath_sync
// Description : 8-bit 6502-style ALU datapath, single-clock model. Each PHI0
//               rising edge stands for one full PHI1/PHI2 period.
//               Pipeline:
//                 edge k   : operand latch (AI/BI)
//                 edge k+1 : operate (ADD, ACR, AVR, DAAL, DAAH)
//                 edge k+2 : BCD correction (ADDC)
// Ports       : PHI0 clock, RES sync active-high reset
//               SB_in/DB_in/ADL_in      : source buses
//               SB_ADD, Z_ADD           : AI load selects (Z_ADD wins)
//               NDB_ADD, ADL_ADD, DB_ADD: BI load selects (in that priority)
//               SUMS/ANDS/EORS/ORS/SRS  : op selects (in that priority)
//               n_ACIN, n_DAA, n_DSA    : active-low carry in / decimal modes
//               ADD_SB06/ADD_SB7/ADD_ADL: result drive enables
//               SB_out/ADL_out          : corrected result, SB_oe/ADL_oe enables
//               n_COUT, AVR, ADD_q      : carry out (low), overflow, raw adder
// Revision    : 1.0  initial release
// ============================================================================
module alu_datapath_sync #(
  parameter int WIDTH = 8
) (
  input  logic             PHI0,
  input  logic             RES,
  input  logic [WIDTH-1:0] SB_in,
  input  logic [WIDTH-1:0] DB_in,
  input  logic [WIDTH-1:0] ADL_in,
  input  logic             SB_ADD,
  input  logic             Z_ADD,
  input  logic             NDB_ADD,
  input  logic             DB_ADD,
  input  logic             ADL_ADD,
  input  logic             SUMS,
  input  logic             ANDS,
  input  logic             EORS,
  input  logic             ORS,
  input  logic             SRS,
  input  logic             n_ACIN,
  input  logic             n_DAA,
  input  logic             n_DSA,
  input  logic             ADD_SB06,
  input  logic             ADD_SB7,
  input  logic             ADD_ADL,
  output logic [WIDTH-1:0] SB_out,
  output logic [1:0]       SB_oe,
  output logic [WIDTH-1:0] ADL_out,
  output logic             ADL_oe,
  output logic             n_COUT,
  output logic             AVR,
  output logic [WIDTH-1:0] ADD_q
);

  // Pipeline state
  logic [WIDTH-1:0] r_ai;
  logic [WIDTH-1:0] r_bi;
  logic [WIDTH-1:0] r_add;
  logic [WIDTH-1:0] r_addc;
  logic             r_acr;
  logic             r_avr;
  logic             r_daal;
  logic             r_daah;
  logic             r_dsa;   // correction direction captured with the op

  // Nibble-split adder; the low-nibble decimal carry feeds the high nibble
  logic       w_cin;
  logic [4:0] w_lo;
  logic       w_dc3;
  logic [4:0] w_hi;
  logic       w_sum_acr;
  logic       w_sum_avr;
  logic       w_sum_daal;
  logic       w_sum_daah;
  logic [WIDTH-1:0] w_and;

  assign w_cin     = ~n_ACIN;
  assign w_lo      = {1'b0, r_ai[3:0]} + {1'b0, r_bi[3:0]} + {4'b0000, w_cin};
  assign w_dc3     = w_lo[4] | (~n_DAA & (w_lo[3:0] > 4'd9));
  assign w_hi      = {1'b0, r_ai[7:4]} + {1'b0, r_bi[7:4]} + {4'b0000, w_dc3};
  assign w_sum_acr = w_hi[4] | (~n_DAA & (w_hi[3:0] > 4'd9));
  // Overflow: same-sign operands producing a result of the other sign
  assign w_sum_avr = (r_ai[7] ~^ r_bi[7]) & (r_ai[7] ^ w_hi[3]);
  // Subtract mode flags a nibble for -6 when it produced no carry (borrow);
  // it overrides add-mode correction if both modes are requested.
  assign w_sum_daal = ~n_DSA ? ~w_lo[4] : (~n_DAA & w_dc3);
  assign w_sum_daah = ~n_DSA ? ~w_hi[4] : (~n_DAA & w_sum_acr);
  assign w_and      = r_ai & r_bi;

  // Operation select
  logic             w_op_valid;
  logic [WIDTH-1:0] w_add_nxt;
  logic             w_acr_nxt;
  logic             w_avr_nxt;
  logic             w_daal_nxt;
  logic             w_daah_nxt;

  always_comb begin
    w_op_valid = SUMS | ANDS | EORS | ORS | SRS;
    w_add_nxt  = r_add;
    w_acr_nxt  = 1'b0;
    w_avr_nxt  = 1'b0;
    w_daal_nxt = 1'b0;
    w_daah_nxt = 1'b0;
    if (SUMS) begin
      w_add_nxt  = {w_hi[3:0], w_lo[3:0]};
      w_acr_nxt  = w_sum_acr;
      w_avr_nxt  = w_sum_avr;
      w_daal_nxt = w_sum_daal;
      w_daah_nxt = w_sum_daah;
    end else if (ANDS) begin
      w_add_nxt = w_and;
    end else if (EORS) begin
      w_add_nxt = r_ai ^ r_bi;
    end else if (ORS) begin
      w_add_nxt = r_ai | r_bi;
    end else if (SRS) begin
      w_add_nxt = {1'b0, w_and[7:1]};
      w_acr_nxt = w_and[0];
    end
  end

  // Decimal correction: independent mod-16 nibble adjust, no inter-nibble carry
  logic [3:0]       w_lo_c;
  logic [3:0]       w_hi_c;
  logic [WIDTH-1:0] w_addc_nxt;

  assign w_lo_c     = r_daal ? (r_dsa ? r_add[3:0] - 4'd6 : r_add[3:0] + 4'd6) : r_add[3:0];
  assign w_hi_c     = r_daah ? (r_dsa ? r_add[7:4] - 4'd6 : r_add[7:4] + 4'd6) : r_add[7:4];
  assign w_addc_nxt = {w_hi_c, w_lo_c};

  always_ff @(posedge PHI0) begin
    if (RES) begin
      r_ai   <= '0;
      r_bi   <= '0;
      r_add  <= '0;
      r_addc <= '0;
      r_acr  <= 1'b0;
      r_avr  <= 1'b0;
      r_daal <= 1'b0;
      r_daah <= 1'b0;
      r_dsa  <= 1'b0;
    end else begin
      if (Z_ADD) begin
        r_ai <= '0;
      end else if (SB_ADD) begin
        r_ai <= SB_in;
      end

      if (NDB_ADD) begin
        r_bi <= ~DB_in;
      end else if (ADL_ADD) begin
        r_bi <= ADL_in;
      end else if (DB_ADD) begin
        r_bi <= DB_in;
      end

      if (w_op_valid) begin
        r_add  <= w_add_nxt;
        r_acr  <= w_acr_nxt;
        r_avr  <= w_avr_nxt;
        r_daal <= w_daal_nxt;
        r_daah <= w_daah_nxt;
        r_dsa  <= ~n_DSA;
      end

      r_addc <= w_addc_nxt;
    end
  end

  assign SB_out  = r_addc;
  assign ADL_out = r_addc;
  assign SB_oe   = {ADD_SB06 & ADD_SB7, ADD_SB06};
  assign ADL_oe  = ADD_ADL;
  assign n_COUT  = ~r_acr;
  assign AVR     = r_avr;
  assign ADD_q   = r_add;

endmodule
`default_nettype wire

// File: tb/tb_alu_datapath_sync.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_datapath_sync
// Description : Self-checking bench for alu_datapath_sync: directed scenarios
//               plus randomized cycles checked against an integer model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_alu_datapath_sync;

  logic       PHI0 = 1'b0;
  logic       RES;
  logic [7:0] SB_in, DB_in, ADL_in;
  logic       SB_ADD, Z_ADD, NDB_ADD, DB_ADD, ADL_ADD;
  logic       SUMS, ANDS, EORS, ORS, SRS;
  logic       n_ACIN, n_DAA, n_DSA;
  logic       ADD_SB06, ADD_SB7, ADD_ADL;
  logic [7:0] SB_out, ADL_out, ADD_q;
  logic [1:0] SB_oe;
  logic       ADL_oe, n_COUT, AVR;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state (plain integers)
  int m_ai, m_bi, m_add, m_acr, m_avr, m_daal, m_daah, m_dsa, m_addc;

  always #5 PHI0 = ~PHI0;

  alu_datapath_sync #(.WIDTH(8)) dut (
    .PHI0(PHI0), .RES(RES),
    .SB_in(SB_in), .DB_in(DB_in), .ADL_in(ADL_in),
    .SB_ADD(SB_ADD), .Z_ADD(Z_ADD), .NDB_ADD(NDB_ADD), .DB_ADD(DB_ADD), .ADL_ADD(ADL_ADD),
    .SUMS(SUMS), .ANDS(ANDS), .EORS(EORS), .ORS(ORS), .SRS(SRS),
    .n_ACIN(n_ACIN), .n_DAA(n_DAA), .n_DSA(n_DSA),
    .ADD_SB06(ADD_SB06), .ADD_SB7(ADD_SB7), .ADD_ADL(ADD_ADL),
    .SB_out(SB_out), .SB_oe(SB_oe), .ADL_out(ADL_out), .ADL_oe(ADL_oe),
    .n_COUT(n_COUT), .AVR(AVR), .ADD_q(ADD_q)
  );

  // Applies one decimal nibble adjustment of +6 / -6, modulo 16
  function automatic int adj(input int nib, input int en, input int sub);
    if (en == 0) return nib;
    return sub ? (nib + 10) % 16 : (nib + 6) % 16;
  endfunction

  // Advance the model by one clock using the inputs currently applied
  task automatic model_step();
    int a, b, cin, dadd, dsub, lo, hi, dc3, res, new_addc;
    if (RES) begin
      m_ai = 0; m_bi = 0; m_add = 0; m_acr = 0; m_avr = 0;
      m_daal = 0; m_daah = 0; m_dsa = 0; m_addc = 0;
      return;
    end
    new_addc = adj(m_add / 16, m_daah, m_dsa) * 16 + adj(m_add % 16, m_daal, m_dsa);
    a = m_ai; b = m_bi; cin = !n_ACIN; dadd = !n_DAA; dsub = !n_DSA;
    if (SUMS) begin
      lo  = a % 16 + b % 16 + cin;
      dc3 = (lo > 15 || (dadd && lo % 16 > 9)) ? 1 : 0;
      hi  = a / 16 + b / 16 + dc3;
      res = (hi % 16) * 16 + lo % 16;
      m_add = res;
      m_acr = (hi > 15 || (dadd && hi % 16 > 9)) ? 1 : 0;
      m_avr = ((a >= 128) == (b >= 128) && (a >= 128) != (res >= 128)) ? 1 : 0;
      if (dsub) begin
        m_daal = (lo < 16) ? 1 : 0;
        m_daah = (hi < 16) ? 1 : 0;
      end else begin
        m_daal = dadd & dc3;
        m_daah = dadd & m_acr;
      end
      m_dsa = dsub;
    end else if (ANDS || EORS || ORS || SRS) begin
      if (ANDS)      m_add = a & b;
      else if (EORS) m_add = a ^ b;
      else if (ORS)  m_add = a | b;
      else           m_add = (a & b) / 2;
      m_acr  = (!ANDS && !EORS && !ORS) ? ((a & b) % 2) : 0;
      m_avr  = 0; m_daal = 0; m_daah = 0; m_dsa = dsub;
    end
    if (Z_ADD)       m_ai = 0;
    else if (SB_ADD) m_ai = SB_in;
    if (NDB_ADD)      m_bi = 255 - DB_in;
    else if (ADL_ADD) m_bi = ADL_in;
    else if (DB_ADD)  m_bi = DB_in;
    m_addc = new_addc;
  endtask

  task automatic tick();
    model_step();
    @(posedge PHI0);
    #1;
  endtask

  task automatic clear_strobes();
    RES = 0; SB_ADD = 0; Z_ADD = 0; NDB_ADD = 0; DB_ADD = 0; ADL_ADD = 0;
    SUMS = 0; ANDS = 0; EORS = 0; ORS = 0; SRS = 0;
    n_ACIN = 1; n_DAA = 1; n_DSA = 1;
    ADD_SB06 = 0; ADD_SB7 = 0; ADD_ADL = 0;
  endtask

  task automatic load(input logic [7:0] a, input logic [7:0] d, input logic inv);
    clear_strobes();
    SB_in = a; SB_ADD = 1; DB_in = d;
    if (inv) NDB_ADD = 1; else DB_ADD = 1;
    tick();
    clear_strobes();
  endtask

  task automatic test_reset();
    clear_strobes();
    SB_in = 8'h00; DB_in = 8'h00; ADL_in = 8'h00;
    RES = 1; tick(); tick(); RES = 0;
    n_tests++; if (ADD_q !== 8'h00) begin n_fail++; $display("FAIL reset_add got %h want 00", ADD_q); end
    n_tests++; if (SB_out !== 8'h00) begin n_fail++; $display("FAIL reset_sb got %h want 00", SB_out); end
    n_tests++; if (ADL_out !== 8'h00) begin n_fail++; $display("FAIL reset_adl got %h want 00", ADL_out); end
    n_tests++; if (n_COUT !== 1'b1 || AVR !== 1'b0) begin
      n_fail++; $display("FAIL reset_flags got cout=%b avr=%b want 1 0", n_COUT, AVR); end
  endtask

  task automatic test_binary_add();
    load(8'h45, 8'h38, 0);
    SUMS = 1; tick(); clear_strobes();
    n_tests++; if (ADD_q !== 8'h7D || n_COUT !== 1'b1 || AVR !== 1'b0) begin
      n_fail++; $display("FAIL bin_add got %h cout=%b avr=%b want 7d 1 0", ADD_q, n_COUT, AVR); end
    tick();
    n_tests++; if (SB_out !== 8'h7D) begin n_fail++; $display("FAIL bin_add_sb got %h want 7d", SB_out); end
    // Operands held: repeating the op reproduces the result
    SUMS = 1; tick(); clear_strobes(); tick();
    n_tests++; if (ADD_q !== 8'h7D || SB_out !== 8'h7D) begin
      n_fail++; $display("FAIL op_hold got %h/%h want 7d/7d", ADD_q, SB_out); end
  endtask

  task automatic test_decimal_add();
    load(8'h45, 8'h38, 0);
    SUMS = 1; n_DAA = 0; tick(); clear_strobes();
    n_tests++; if (ADD_q !== 8'h8D || n_COUT !== 1'b1) begin
      n_fail++; $display("FAIL dec_add got %h cout=%b want 8d 1", ADD_q, n_COUT); end
    tick();
    n_tests++; if (SB_out !== 8'h83) begin n_fail++; $display("FAIL dec_add_sb got %h want 83", SB_out); end
  endtask

  task automatic test_decimal_sub();
    load(8'h50, 8'h01, 1);
    SUMS = 1; n_ACIN = 0; n_DSA = 0; tick(); clear_strobes();
    n_tests++; if (ADD_q !== 8'h4F || n_COUT !== 1'b0) begin
      n_fail++; $display("FAIL dec_sub got %h cout=%b want 4f 0", ADD_q, n_COUT); end
    tick();
    n_tests++; if (SB_out !== 8'h49 || ADL_out !== 8'h49) begin
      n_fail++; $display("FAIL dec_sub_out got %h/%h want 49/49", SB_out, ADL_out); end
  endtask

  task automatic test_overflow_shift();
    load(8'h50, 8'h50, 0);
    SUMS = 1; tick(); clear_strobes();
    n_tests++; if (ADD_q !== 8'hA0 || AVR !== 1'b1 || n_COUT !== 1'b1) begin
      n_fail++; $display("FAIL overflow got %h avr=%b cout=%b want a0 1 1", ADD_q, AVR, n_COUT); end
    load(8'h81, 8'hFF, 0);
    SRS = 1; tick(); clear_strobes();
    n_tests++; if (ADD_q !== 8'h40 || AVR !== 1'b0 || n_COUT !== 1'b0) begin
      n_fail++; $display("FAIL shift got %h avr=%b cout=%b want 40 0 0", ADD_q, AVR, n_COUT); end
  endtask

  task automatic test_priority_lanes();
    clear_strobes();
    SB_in = 8'h77; SB_ADD = 1; Z_ADD = 1; DB_in = 8'h0F; NDB_ADD = 1; DB_ADD = 1;
    tick(); clear_strobes();
    ORS = 1; EORS = 1; tick(); clear_strobes();   // EORS outranks ORS: 00 ^ F0
    n_tests++; if (ADD_q !== 8'hF0) begin n_fail++; $display("FAIL load_priority got %h want f0", ADD_q); end
    ADL_in = 8'h3C; ADL_ADD = 1; DB_ADD = 1; SB_in = 8'h0F; SB_ADD = 1; tick(); clear_strobes();
    ANDS = 1; SUMS = 1; tick(); clear_strobes();  // SUMS outranks ANDS: 0F + 3C
    n_tests++; if (ADD_q !== 8'h4B) begin n_fail++; $display("FAIL op_priority got %h want 4b", ADD_q); end
    ADD_SB06 = 1; ADD_SB7 = 0; #1;
    n_tests++; if (SB_oe !== 2'b01) begin n_fail++; $display("FAIL lanes_06 got %b want 01", SB_oe); end
    ADD_SB7 = 1; ADD_ADL = 1; #1;
    n_tests++; if (SB_oe !== 2'b11 || ADL_oe !== 1'b1) begin
      n_fail++; $display("FAIL lanes_all got %b %b want 11 1", SB_oe, ADL_oe); end
    ADD_SB06 = 0; ADD_ADL = 0; #1;
    n_tests++; if (SB_oe !== 2'b00 || ADL_oe !== 1'b0) begin
      n_fail++; $display("FAIL lanes_7only got %b %b want 00 0", SB_oe, ADL_oe); end
    clear_strobes();
  endtask

  task automatic test_back_to_back();
    load(8'h12, 8'h34, 0);
    SUMS = 1; SB_in = 8'hF0; SB_ADD = 1; DB_in = 8'h3C; DB_ADD = 1; tick(); clear_strobes();
    n_tests++; if (ADD_q !== 8'h46) begin n_fail++; $display("FAIL b2b_first got %h want 46", ADD_q); end
    EORS = 1; tick(); clear_strobes();
    n_tests++; if (ADD_q !== 8'hCC || SB_out !== 8'h46) begin
      n_fail++; $display("FAIL b2b_second got %h/%h want cc/46", ADD_q, SB_out); end
    tick();
    n_tests++; if (SB_out !== 8'hCC) begin n_fail++; $display("FAIL b2b_out got %h want cc", SB_out); end
  endtask

  task automatic test_reset_mid_op();
    load(8'h45, 8'h38, 0);
    SUMS = 1; RES = 1; tick(); clear_strobes();
    n_tests++; if (ADD_q !== 8'h00 || n_COUT !== 1'b1 || AVR !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid got %h cout=%b avr=%b want 00 1 0", ADD_q, n_COUT, AVR); end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++; if (ADD_q !== 8'h00 || SB_out !== 8'h00) begin
        n_fail++; $display("FAIL rst_hold cyc %0d got %h/%h want 00/00", i, ADD_q, SB_out); end
    end
    SUMS = 1; tick(); clear_strobes();            // operands were cleared too
    n_tests++; if (ADD_q !== 8'h00) begin n_fail++; $display("FAIL rst_operands got %h want 00", ADD_q); end
  endtask

  task automatic test_random();
    int r;
    for (int i = 0; i < 400; i++) begin
      SB_in = 8'($urandom); DB_in = 8'($urandom); ADL_in = 8'($urandom);
      r = $urandom;
      SB_ADD = r[0]; Z_ADD = (r[4:1] == 0); NDB_ADD = (r[7:5] == 0);
      DB_ADD = r[8]; ADL_ADD = r[9];
      SUMS = r[10] & r[11]; ANDS = (r[14:12] == 0); EORS = (r[17:15] == 0);
      ORS = (r[20:18] == 0); SRS = (r[23:21] == 0);
      n_ACIN = r[24]; n_DAA = r[25]; n_DSA = r[26] | r[27];
      RES = (r[31:27] == 0);
      tick();
      n_tests++; if (ADD_q !== 8'(m_add) || n_COUT !== !m_acr[0] || AVR !== m_avr[0]) begin
        n_fail++; $display("FAIL rand_op cyc %0d got %h cout=%b avr=%b want %h %b %b",
                           i, ADD_q, n_COUT, AVR, 8'(m_add), !m_acr[0], m_avr[0]); end
      n_tests++; if (SB_out !== 8'(m_addc) || ADL_out !== 8'(m_addc)) begin
        n_fail++; $display("FAIL rand_out cyc %0d got %h/%h want %h", i, SB_out, ADL_out, 8'(m_addc)); end
    end
    clear_strobes();
  endtask

  initial begin
    clear_strobes();
    SB_in = 0; DB_in = 0; ADL_in = 0;
    test_reset();
    test_binary_add();
    test_decimal_add();
    test_decimal_sub();
    test_overflow_shift();
    test_priority_lanes();
    test_back_to_back();
    test_reset_mid_op();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
